// File: rtl/ex_div_pkg.sv
// Shared constants and state encoding for the execute-stage divider.
package ex_div_pkg;
  localparam int RegBus       = 32;
  localparam int DoubleRegBus = 64;

  localparam logic              RstEnable         = 1'b1;
  localparam logic              DivResultReady    = 1'b1;
  localparam logic              DivResultNotReady = 1'b0;
  localparam logic              DivStart          = 1'b1;
  localparam logic              DivStop           = 1'b0;
  localparam logic [RegBus-1:0] ZeroWord          = '0;

  typedef enum logic [1:0] {
    DivFree   = 2'b00,
    DivByZero = 2'b01,
    DivOn     = 2'b10,
    DivEnd    = 2'b11
  } div_state_e;
endpackage

// File: rtl/ex_div_if.sv
// EX <-> divider handshake: operands and start/annul in, {remainder, quotient} and ready out.
interface ex_div_if;
  import ex_div_pkg::*;

  logic                    signed_div_i;
  logic [RegBus-1:0]       opdata1_i;
  logic [RegBus-1:0]       opdata2_i;
  logic                    start_i;
  logic                    annul_i;
  logic [DoubleRegBus-1:0] result_o;
  logic                    ready_o;

  modport master (
    output signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
    input  result_o, ready_o
  );

  modport slave (
    input  signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
    output result_o, ready_o
  );
endinterface

// File: rtl/ex_div_step.sv
// One radix-2 restoring step: trial-subtract the divisor from the top 33 bits, shift in the quotient bit.
module div_step
  import ex_div_pkg::*;
(
  input  logic [DoubleRegBus:0] dividend_i,
  input  logic [RegBus-1:0]     divisor_i,
  output logic [DoubleRegBus:0] dividend_o
);
  logic [RegBus:0] diff;

  // Partial remainder is always < divisor, so a set MSB here means a borrow.
  assign diff = dividend_i[DoubleRegBus:RegBus] - {1'b0, divisor_i};

  always_comb begin
    dividend_o = {dividend_i[DoubleRegBus-1:0], 1'b0};
    if (!diff[RegBus])
      dividend_o = {diff[RegBus-1:0], dividend_i[RegBus-1:0], 1'b1};
  end
endmodule

// File: rtl/ex_div.sv
// Multi-cycle 32-bit restoring divider (DIV/DIVU), one quotient bit per clock.
// Signed support is built only when DIV_SIGNED_EN is defined; otherwise all operations are unsigned.
module ex_div
  import ex_div_pkg::*;
(
  input  logic     clk,
  input  logic     rst,
  ex_div_if.slave  div_if
);
  div_state_e              state_q;
  logic [5:0]              cnt_q;
  logic [DoubleRegBus:0]   dividend_q;
  logic [DoubleRegBus:0]   dividend_d;
  logic [RegBus-1:0]       divisor_q;
  logic [DoubleRegBus-1:0] result_q;
  logic                    ready_q;

  logic [RegBus-1:0]       op1_abs, op2_abs;
  logic [RegBus-1:0]       quo_fix, rem_fix;
  logic [RegBus-1:0]       quo_raw, rem_raw;

  assign quo_raw = dividend_q[RegBus-1:0];
  assign rem_raw = dividend_q[DoubleRegBus:RegBus+1];

`ifdef DIV_SIGNED_EN
  logic neg1, neg2;
  logic sign1_q, sign2_q;

  assign neg1    = div_if.signed_div_i & div_if.opdata1_i[RegBus-1];
  assign neg2    = div_if.signed_div_i & div_if.opdata2_i[RegBus-1];
  assign op1_abs = neg1 ? (~div_if.opdata1_i + 1'b1) : div_if.opdata1_i;
  assign op2_abs = neg2 ? (~div_if.opdata2_i + 1'b1) : div_if.opdata2_i;
  // Quotient sign follows the operand signs; remainder follows the dividend.
  assign quo_fix = (sign1_q ^ sign2_q) ? (~quo_raw + 1'b1) : quo_raw;
  assign rem_fix = sign1_q ? (~rem_raw + 1'b1) : rem_raw;
`else
  assign op1_abs = div_if.opdata1_i;
  assign op2_abs = div_if.opdata2_i;
  assign quo_fix = quo_raw;
  assign rem_fix = rem_raw;
`endif

  div_step u_step (
    .dividend_i (dividend_q),
    .divisor_i  (divisor_q),
    .dividend_o (dividend_d)
  );

  always_ff @(posedge clk) begin
    if (rst == RstEnable) begin
      state_q    <= DivFree;
      cnt_q      <= '0;
      dividend_q <= '0;
      divisor_q  <= '0;
      result_q   <= '0;
      ready_q    <= DivResultNotReady;
`ifdef DIV_SIGNED_EN
      sign1_q    <= 1'b0;
      sign2_q    <= 1'b0;
`endif
    end else begin
      case (state_q)
        DivFree: begin
          if (div_if.start_i == DivStart && !div_if.annul_i) begin
            if (div_if.opdata2_i == ZeroWord) begin
              state_q <= DivByZero;
            end else begin
              state_q    <= DivOn;
              cnt_q      <= '0;
              dividend_q <= {ZeroWord, op1_abs, 1'b0};
              divisor_q  <= op2_abs;
`ifdef DIV_SIGNED_EN
              sign1_q    <= neg1;
              sign2_q    <= neg2;
`endif
            end
          end else begin
            ready_q  <= DivResultNotReady;
            result_q <= '0;
          end
        end
        DivByZero: begin
          dividend_q <= '0;
          result_q   <= '0;
          ready_q    <= DivResultReady;
          state_q    <= DivEnd;
        end
        DivOn: begin
          if (div_if.annul_i) begin
            state_q  <= DivFree;
            cnt_q    <= '0;
            result_q <= '0;
            ready_q  <= DivResultNotReady;
          end else if (cnt_q != 6'd32) begin
            dividend_q <= dividend_d;
            cnt_q      <= cnt_q + 6'd1;
          end else begin
            result_q <= {rem_fix, quo_fix};
            ready_q  <= DivResultReady;
            cnt_q    <= '0;
            state_q  <= DivEnd;
          end
        end
        DivEnd: begin
          if (div_if.start_i == DivStop) begin
            state_q  <= DivFree;
            ready_q  <= DivResultNotReady;
            result_q <= '0;
          end
        end
        default: state_q <= DivFree;
      endcase
    end
  end

  assign div_if.result_o = result_q;
  assign div_if.ready_o  = ready_q;
endmodule

// File: tb/tb_ex_div.sv
// Directed bench for ex_div: vector table for full divisions plus hand sequences for zero-divide, annul and reset.
module tb_ex_div;
  logic clk = 1'b0;
  logic rst;
  int   n_chk  = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  ex_div_if u_if ();

  ex_div u_dut (
    .clk    (clk),
    .rst    (rst),
    .div_if (u_if.slave)
  );

  typedef struct {
    logic        sg;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] q;
    logic [31:0] r;
  } vec_t;

  vec_t vecs[10];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Full operation: E0 start, 32 busy edges, result at E33, held while start stays high.
  task automatic run_div(input string nm, input logic sg, input logic [31:0] a, input logic [31:0] b,
                         input logic [63:0] exp);
    logic busy_bad;
    logic hold_bad;
    busy_bad = 1'b0;
    hold_bad = 1'b0;
    u_if.signed_div_i = sg;
    u_if.opdata1_i    = a;
    u_if.opdata2_i    = b;
    u_if.start_i      = 1'b1;
    tick();
    u_if.signed_div_i = ~sg;
    u_if.opdata1_i    = ~a;
    u_if.opdata2_i    = b ^ 32'h5A5A_0001;
    for (int k = 1; k <= 32; k++) begin
      tick();
      if (u_if.ready_o !== 1'b0) busy_bad = 1'b1;
    end
    chk({nm, " busy"}, {63'd0, busy_bad}, 64'd0);
    tick();
    chk({nm, " ready"}, {63'd0, u_if.ready_o}, 64'd1);
    chk({nm, " result"}, u_if.result_o, exp);
    for (int k = 0; k < 5; k++) begin
      tick();
      if (u_if.ready_o !== 1'b1 || u_if.result_o !== exp) hold_bad = 1'b1;
    end
    chk({nm, " hold"}, {63'd0, hold_bad}, 64'd0);
    u_if.start_i = 1'b0;
    tick();
    chk({nm, " release"}, {u_if.result_o[62:0], u_if.ready_o}, 64'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{1'b0, 32'd100,        32'd7,          32'd14,         32'd2};
    vecs[1] = '{1'b0, 32'h1234_5678,  32'h0000_1000,  32'h0001_2345,  32'h0000_0678};
    vecs[2] = '{1'b0, 32'hFFFF_FFFF,  32'd1,          32'hFFFF_FFFF,  32'd0};
    vecs[3] = '{1'b0, 32'd7,          32'd100,        32'd0,          32'd7};
    vecs[4] = '{1'b0, 32'hFFFF_FFFF,  32'h8000_0001,  32'd1,          32'h7FFF_FFFE};
    vecs[5] = '{1'b0, 32'hFFFF_FF9C,  32'd7,          32'h2492_4916,  32'd2};
`ifdef DIV_SIGNED_EN
    vecs[6] = '{1'b1, 32'hFFFF_FF9C,  32'd7,          32'hFFFF_FFF2,  32'hFFFF_FFFE};
    vecs[7] = '{1'b1, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  32'd0};
    vecs[8] = '{1'b1, 32'd100,        32'hFFFF_FFF9,  32'hFFFF_FFF2,  32'd2};
    vecs[9] = '{1'b1, 32'hFFFF_FF9C,  32'hFFFF_FFF9,  32'd14,         32'hFFFF_FFFE};
`else
    vecs[6] = '{1'b1, 32'hFFFF_FF9C,  32'd7,          32'h2492_4916,  32'd2};
    vecs[7] = '{1'b1, 32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          32'h8000_0000};
    vecs[8] = '{1'b1, 32'd100,        32'hFFFF_FFF9,  32'd0,          32'd100};
    vecs[9] = '{1'b1, 32'hFFFF_FF9C,  32'hFFFF_FFF9,  32'd0,          32'hFFFF_FF9C};
`endif

    rst = 1'b1;
    u_if.signed_div_i = 1'b0;
    u_if.opdata1_i    = '0;
    u_if.opdata2_i    = '0;
    u_if.start_i      = 1'b0;
    u_if.annul_i      = 1'b0;
    tick();
    tick();
    chk("reset ready", {63'd0, u_if.ready_o}, 64'd0);
    chk("reset result", u_if.result_o, 64'd0);
    rst = 1'b0;
    tick();

    for (int i = 0; i < 10; i++)
      run_div($sformatf("vec%0d", i), vecs[i].sg, vecs[i].a, vecs[i].b, {vecs[i].r, vecs[i].q});

    // Divide by zero: ready one edge after the start edge, result zero.
    u_if.opdata1_i = 32'd5;
    u_if.opdata2_i = 32'd0;
    u_if.start_i   = 1'b1;
    tick();
    chk("dbz E0 ready", {63'd0, u_if.ready_o}, 64'd0);
    tick();
    chk("dbz E1 ready", {63'd0, u_if.ready_o}, 64'd1);
    chk("dbz E1 result", u_if.result_o, 64'd0);
    tick();
    chk("dbz hold ready", {63'd0, u_if.ready_o}, 64'd1);
    u_if.start_i = 1'b0;
    tick();
    chk("dbz release ready", {63'd0, u_if.ready_o}, 64'd0);

    // Annul at E10, then a fresh 9/3.
    u_if.opdata1_i = 32'd100;
    u_if.opdata2_i = 32'd7;
    u_if.start_i   = 1'b1;
    tick();
    repeat (9) tick();
    u_if.annul_i = 1'b1;
    u_if.start_i = 1'b0;
    tick();
    chk("annul ready", {63'd0, u_if.ready_o}, 64'd0);
    chk("annul result", u_if.result_o, 64'd0);
    u_if.annul_i = 1'b0;
    tick();
    run_div("after annul", 1'b0, 32'd9, 32'd3, {32'd0, 32'd3});

    // Start together with annul must not launch an operation.
    u_if.opdata1_i = 32'd100;
    u_if.opdata2_i = 32'd7;
    u_if.start_i   = 1'b1;
    u_if.annul_i   = 1'b1;
    repeat (3) tick();
    chk("start+annul ready", {63'd0, u_if.ready_o}, 64'd0);
    u_if.start_i = 1'b0;
    u_if.annul_i = 1'b0;
    tick();
    run_div("after start+annul", 1'b0, 32'd100, 32'd7, {32'd2, 32'd14});

    // Reset at E20 discards the operation.
    u_if.opdata1_i = 32'd100;
    u_if.opdata2_i = 32'd7;
    u_if.start_i   = 1'b1;
    tick();
    repeat (19) tick();
    rst = 1'b1;
    tick();
    chk("midreset ready", {63'd0, u_if.ready_o}, 64'd0);
    chk("midreset result", u_if.result_o, 64'd0);
    rst = 1'b0;
    u_if.start_i = 1'b0;
    tick();
    run_div("after reset", 1'b0, 32'd9, 32'd3, {32'd0, 32'd3});

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
